// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the clk_load_sched field-load scheduler.
package clk_ctrl_pkg;

  localparam logic [1:0] SEL_FOO = 2'b00;
  localparam logic [1:0] SEL_BAZ = 2'b01;
  localparam logic [1:0] SEL_EGG = 2'b10;
  localparam logic [1:0] SEL_ALL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int unsigned FOO_W_DEF = 14;
  localparam int unsigned BAZ_W     = 3;
  localparam int unsigned EGG_W     = 3;

  localparam int unsigned BAZ_LSB = 0;
  localparam int unsigned EGG_LSB = 4;

  localparam logic [FOO_W_DEF-1:0] FOO_RST_DEF = '1;
  localparam logic [BAZ_W-1:0]     BAZ_RST     = '0;
  localparam logic [EGG_W-1:0]     EGG_RST     = '0;

  // Strobe mask ordering is {egg, baz, foo}.
  function automatic logic [2:0] sel_decode(input logic [1:0] sel);
    logic [2:0] m;
    m = 3'b000;
    unique case (sel)
      SEL_FOO: m = 3'b001;
      SEL_BAZ: m = 3'b010;
      SEL_EGG: m = 3'b100;
      SEL_ALL: m = 3'b111;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/clk_load_sched_if.sv
// Requester-side bus of clk_load_sched: request level, target, word, grant and completion.
interface clk_load_sched_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]    req;
  logic [2*NREQ-1:0]  req_sel;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;

  modport master (output req, req_sel, req_data, input gnt, ack);
  modport slave  (input req, req_sel, req_data, output gnt, ack);
endinterface

// File: rtl/clk_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping to 0.
module clk_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic            valid
);

  logic [PW-1:0] idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PW'((32'(ptr) + k) % NREQ);
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_load_sched.sv
// Round-robin scheduler for the shared ival load path; owns the foo/baz/egg field copies.
// Optional counters are enabled with CLK_LOAD_SCHED_STATS_EN.
module clk_load_sched
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned FOO_W = FOO_W_DEF
) (
  input  logic              sysclk,
  input  logic              reset,
  clk_load_sched_if.slave   bus,
  output logic [31:0]       ival,
  output logic              ld_foo,
  output logic              ld_baz,
  output logic              ld_egg,
  output logic [FOO_W-1:0]  foo_q,
  output logic [BAZ_W-1:0]  baz_q,
  output logic [EGG_W-1:0]  egg_q,
  output logic              busy
`ifdef CLK_LOAD_SCHED_STATS_EN
  ,
  output logic [15:0]       foo_cnt,
  output logic [15:0]       baz_cnt,
  output logic [15:0]       egg_cnt,
  output logic [7:0]        abort_cnt
`endif
);

  localparam int unsigned PW = $clog2(NREQ);

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [31:0]       cap_data_q, cap_data_d;
  logic [1:0]        cap_sel_q, cap_sel_d;
  logic [2:0]        ld_q, ld_d;
  logic [31:0]       ival_q, ival_d;
  logic [FOO_W-1:0]  foo_d;
  logic [BAZ_W-1:0]  baz_d;
  logic [EGG_W-1:0]  egg_d;

  logic [NREQ-1:0]   arb_win;
  logic              arb_valid;
  logic [PW-1:0]     win_idx;
  logic [1:0]        sel_a  [NREQ];
  logic [31:0]       data_a [NREQ];

  clk_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req   (bus.req),
    .ptr   (ptr_q),
    .win   (arb_win),
    .valid (arb_valid)
  );

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign sel_a[g]  = bus.req_sel[2*g+1:2*g];
    assign data_a[g] = bus.req_data[32*g+31:32*g];
  end

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_win[i]) win_idx = PW'(i);
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] w);
    return (w == PW'(NREQ - 1)) ? '0 : w + 1'b1;
  endfunction

  // LOAD spans two cycles: a check cycle (ld_q clear) that may abort, then the
  // strobe cycle; the edge leaving the strobe cycle commits fields and enters ACK.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    ptr_d      = ptr_q;
    win_d      = win_q;
    cap_data_d = cap_data_q;
    cap_sel_d  = cap_sel_q;
    ld_d       = '0;
    ival_d     = '0;
    foo_d      = foo_q;
    baz_d      = baz_q;
    egg_d      = egg_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_d      = arb_win;
          win_d      = win_idx;
          cap_data_d = data_a[win_idx];
          cap_sel_d  = sel_a[win_idx];
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (ld_q == '0) begin
          if (bus.req[win_q]) begin
            ld_d   = sel_decode(cap_sel_q);
            ival_d = cap_data_q;
          end else begin
            gnt_d   = '0;
            ptr_d   = ptr_inc(win_q);
            state_d = IDLE;
          end
        end else begin
          if (ld_q[0]) foo_d = ival_q[31 -: FOO_W];
          if (ld_q[1]) baz_d = ival_q[BAZ_LSB +: BAZ_W];
          if (ld_q[2]) egg_d = ival_q[EGG_LSB +: EGG_W];
          ack_d   = gnt_q;
          state_d = ACK;
        end
      end
      ACK: begin
        gnt_d   = '0;
        ptr_d   = ptr_inc(win_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ack_q      <= '0;
      ptr_q      <= '0;
      win_q      <= '0;
      cap_data_q <= '0;
      cap_sel_q  <= '0;
      ld_q       <= '0;
      ival_q     <= '0;
      foo_q      <= '1;
      baz_q      <= BAZ_RST;
      egg_q      <= EGG_RST;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      cap_data_q <= cap_data_d;
      cap_sel_q  <= cap_sel_d;
      ld_q       <= ld_d;
      ival_q     <= ival_d;
      foo_q      <= foo_d;
      baz_q      <= baz_d;
      egg_q      <= egg_d;
    end
  end

  assign bus.gnt = gnt_q;
  assign bus.ack = ack_q;
  assign ival    = ival_q;
  assign ld_foo  = ld_q[0];
  assign ld_baz  = ld_q[1];
  assign ld_egg  = ld_q[2];
  assign busy    = (state_q != IDLE);

`ifdef CLK_LOAD_SCHED_STATS_EN
  logic abort;
  assign abort = (state_q == LOAD) && (ld_q == '0) && !bus.req[win_q];

  always_ff @(posedge sysclk) begin
    if (reset) begin
      foo_cnt   <= '0;
      baz_cnt   <= '0;
      egg_cnt   <= '0;
      abort_cnt <= '0;
    end else begin
      if (ld_q[0] && (foo_cnt != '1)) foo_cnt <= foo_cnt + 1'b1;
      if (ld_q[1] && (baz_cnt != '1)) baz_cnt <= baz_cnt + 1'b1;
      if (ld_q[2] && (egg_cnt != '1)) egg_cnt <= egg_cnt + 1'b1;
      if (abort && (abort_cnt != '1)) abort_cnt <= abort_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_clk_load_sched.sv
// Scoreboard bench for clk_load_sched: a transaction-level model predicts grant order
// and field contents; a negedge monitor checks strobes, acks and field stability.
module tb_clk_load_sched;

  localparam int NREQ = 4;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;

  clk_load_sched_if #(.NREQ(NREQ)) bus ();

  logic [31:0] ival;
  logic        ld_foo, ld_baz, ld_egg, busy;
  logic [13:0] foo_q;
  logic [2:0]  baz_q, egg_q;
`ifdef CLK_LOAD_SCHED_STATS_EN
  logic [15:0] foo_cnt, baz_cnt, egg_cnt;
  logic [7:0]  abort_cnt;
`endif

  clk_load_sched #(.NREQ(NREQ), .FOO_W(14)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus),
    .ival   (ival),
    .ld_foo (ld_foo),
    .ld_baz (ld_baz),
    .ld_egg (ld_egg),
    .foo_q  (foo_q),
    .baz_q  (baz_q),
    .egg_q  (egg_q),
    .busy   (busy)
`ifdef CLK_LOAD_SCHED_STATS_EN
    ,
    .foo_cnt   (foo_cnt),
    .baz_cnt   (baz_cnt),
    .egg_cnt   (egg_cnt),
    .abort_cnt (abort_cnt)
`endif
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int          win;
    logic [2:0]  mask;
    logic [31:0] data;
    logic [13:0] foo;
    logic [2:0]  baz;
    logic [2:0]  egg;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic [13:0] mfoo = '1;
  logic [2:0]  mbaz = '0, megg = '0;
  bit          prev_ld = 0;

  always @(negedge sysclk) begin
    logic [2:0]      ldv;
    logic [NREQ-1:0] oh;
    exp_t            e;
    if (reset) begin
      q.delete();
      mfoo = '1; mbaz = '0; megg = '0;
      prev_ld = 0;
    end else begin
      ldv = {ld_egg, ld_baz, ld_foo};
      if (ldv != 3'b000) begin
        if (q.size() == 0) chk("ld_unexpected", 32'(ldv), 32'd0);
        else begin
          chk("ld_mask", 32'(ldv), 32'(q[0].mask));
          chk("ival", ival, q[0].data);
        end
      end
      if (bus.ack != '0) begin
        if (q.size() == 0) chk("ack_unexpected", 32'(bus.ack), 32'd0);
        else begin
          e = q.pop_front();
          oh = '0; oh[e.win] = 1'b1;
          chk("ack_onehot", 32'(bus.ack), 32'(oh));
          chk("gnt_in_ack", 32'(bus.gnt), 32'(oh));
          chk("ack_after_ld", 32'(prev_ld), 32'd1);
          chk("foo_q", 32'(foo_q), 32'(e.foo));
          chk("baz_q", 32'(baz_q), 32'(e.baz));
          chk("egg_q", 32'(egg_q), 32'(e.egg));
          mfoo = e.foo; mbaz = e.baz; megg = e.egg;
        end
      end else begin
        chk("fields_hold", {12'd0, foo_q, baz_q, egg_q}, {12'd0, mfoo, mbaz, megg});
      end
      prev_ld = (ldv != 3'b000);
    end
  end

  // ---------------- reference model + stimulus ----------------
  int          mptr = 0;
  logic [13:0] sfoo = '1;
  logic [2:0]  sbaz = '0, segg = '0;
  int          nfoo = 0, nbaz = 0, negg = 0, nabort = 0;
  logic [1:0]  rsel  [NREQ];
  logic [31:0] rdata [NREQ];

  task automatic tick();
    @(negedge sysclk);
    for (int i = 0; i < NREQ; i++) if (bus.ack[i]) bus.req[i] = 1'b0;
  endtask

  function automatic int pick(input logic [NREQ-1:0] pend, input int ptr);
    for (int k = 0; k < NREQ; k++) if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [2:0] sel_mask(input logic [1:0] s);
    case (s)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      2'b10:   return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    while ((bus.req != '0 || busy) && n < 100) begin tick(); n++; end
    if (n >= 100) chk("idle_timeout", 32'(n), 32'd0);
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic run_round(input logic [NREQ-1:0] mask, input bit lat);
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] oh;
    exp_t e;
    int w, first;
    for (int i = 0; i < NREQ; i++) if (mask[i]) begin
      bus.req_sel[2*i +: 2]   = rsel[i];
      bus.req_data[32*i +: 32] = rdata[i];
    end
    bus.req = bus.req | mask;
    pend = mask;
    first = pick(pend, mptr);
    while (pend != '0) begin
      w = pick(pend, mptr);
      e.win = w; e.mask = sel_mask(rsel[w]); e.data = rdata[w];
      if (e.mask[0]) begin sfoo = rdata[w][31:18]; nfoo++; end
      if (e.mask[1]) begin sbaz = rdata[w][2:0];   nbaz++; end
      if (e.mask[2]) begin segg = rdata[w][6:4];   negg++; end
      e.foo = sfoo; e.baz = sbaz; e.egg = segg;
      q.push_back(e);
      pend[w] = 1'b0;
      mptr = (w + 1) % NREQ;
    end
    if (lat) begin
      oh = '0; oh[first] = 1'b1;
      tick(); chk("gnt_at_1", 32'(bus.gnt), 32'(oh)); chk("busy_at_1", 32'(busy), 32'd1);
      chk("no_ld_at_1", 32'({ld_egg, ld_baz, ld_foo}), 32'd0);
      tick(); chk("ld_at_2", 32'({ld_egg, ld_baz, ld_foo}), 32'(sel_mask(rsel[first])));
      chk("no_ack_at_2", 32'(bus.ack), 32'd0);
      tick(); chk("ack_at_3", 32'(bus.ack), 32'(oh));
      tick(); chk("idle_at_4", 32'(busy), 32'd0);
    end
    wait_idle();
  endtask

  task automatic run_abort(input int r);
    logic [NREQ-1:0] oh;
    oh = '0; oh[r] = 1'b1;
    bus.req_sel[2*r +: 2]    = 2'($urandom_range(0, 3));
    bus.req_data[32*r +: 32] = $urandom;
    bus.req[r] = 1'b1;
    tick(); chk("abort_gnt", 32'(bus.gnt), 32'(oh));
    bus.req[r] = 1'b0;
    tick(); chk("abort_gnt_clr", 32'(bus.gnt), 32'd0); chk("abort_idle", 32'(busy), 32'd0);
    tick(); tick();
    mptr = (r + 1) % NREQ;
    nabort++;
  endtask

  initial begin
    bus.req = '0; bus.req_sel = '0; bus.req_data = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_foo", 32'(foo_q), 32'h3FFF);
    chk("rst_baz", 32'(baz_q), 32'd0);
    chk("rst_egg", 32'(egg_q), 32'd0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack_ld", {28'd0, bus.ack != '0, ld_foo, ld_baz, ld_egg}, 32'd0);

    rsel[1] = 2'b00; rdata[1] = 32'hABCD_1234;
    run_round(4'b0010, 1'b1);
    chk("single_foo", 32'(foo_q), 32'h2AF3);

    rsel[2] = 2'b11; rdata[2] = 32'hFFFF_FF75;
    run_round(4'b0100, 1'b1);
    chk("bcast_fields", {18'd0, foo_q, baz_q, egg_q}, {18'd0, 14'h3FFF, 3'b101, 3'b111});

    run_abort(3);
`ifdef CLK_LOAD_SCHED_STATS_EN
    chk("abort_cnt", 32'(abort_cnt), 32'd1);
`endif

    for (int i = 0; i < NREQ; i++) begin rsel[i] = 2'b01; rdata[i] = 32'(i + 1); end
    run_round(4'b1111, 1'b0);
    chk("fair_last_baz", 32'(baz_q), 32'd4);

    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 4) == 0) run_abort($urandom_range(0, NREQ - 1));
      else begin
        for (int i = 0; i < NREQ; i++) begin
          rsel[i] = 2'($urandom_range(0, 3)); rdata[i] = $urandom;
        end
        run_round(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 1'b0);
      end
    end
`ifdef CLK_LOAD_SCHED_STATS_EN
    chk("foo_cnt", 32'(foo_cnt), 32'(nfoo));
    chk("baz_cnt", 32'(baz_cnt), 32'(nbaz));
    chk("egg_cnt", 32'(egg_cnt), 32'(negg));
    chk("abort_cnt_all", 32'(abort_cnt), 32'(nabort));
`endif

    // Reset landing in the ld_egg cycle must discard the pending write.
    rsel[2] = 2'b10; rdata[2] = 32'h0000_0060;
    bus.req_sel[5:4] = rsel[2]; bus.req_data[95:64] = rdata[2];
    bus.req[2] = 1'b1;
    begin
      exp_t e;
      e.win = 2; e.mask = 3'b100; e.data = rdata[2]; e.foo = sfoo; e.baz = sbaz; e.egg = 3'd6;
      q.push_back(e);
    end
    begin
      int n = 0;
      while (!ld_egg && n < 10) begin tick(); n++; end
      chk("midop_ld_egg_seen", 32'(ld_egg), 32'd1);
    end
    reset = 1'b1;
    tick();
    bus.req = '0;
    reset = 1'b0;
    mptr = 0; sfoo = '1; sbaz = '0; segg = '0;
    chk("midop_egg", 32'(egg_q), 32'd0);
    chk("midop_foo", 32'(foo_q), 32'h3FFF);
    chk("midop_busy", 32'(busy), 32'd0);
    chk("midop_ack_gnt", {bus.ack, bus.gnt}, 32'd0);
`ifdef CLK_LOAD_SCHED_STATS_EN
    chk("midop_abort_cnt", 32'(abort_cnt), 32'd0);
`endif
    tick();
    chk("midop_no_ack", 32'(bus.ack), 32'd0);
    for (int i = 0; i < NREQ; i++) begin rsel[i] = 2'b01; rdata[i] = 32'(i + 1); end
    run_round(4'b1111, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
